// File: rtl/br_pkg.sv
// Shared definitions for the EX-stage branch resolution unit.
package br_pkg;

    // Conditional-branch funct3 encodings (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Redirect sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } br_state_t;

    // Width of the post-redirect squash counter (covers FLUSH_CYCLES up to 7)
    localparam int unsigned SQ_CNT_W = 3;

endpackage

// File: rtl/br_cond.sv
// Combinational taken/illegal decode for branches and jumps.
module br_cond
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       is_jump,
    input  logic       br_less,
    input  logic       br_equal,
    output logic       taken,
    output logic       illegal
);

    // Jumps are unconditional; branches select equal/less and optional inversion
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                F3_BEQ:           taken = br_equal;
                F3_BNE:           taken = !br_equal;
                F3_BLT, F3_BLTU:  taken = br_less;
                F3_BGE, F3_BGEU:  taken = !br_less;
                default:          illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: decides taken, issues a registered PC redirect
// with valid/ready handshake, flushes IF/ID and squashes wrong-path EX work.
module br_resolve
    import br_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic        ex_stall_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_target_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    output logic        redirect_valid_o,
    input  logic        redirect_ready_i,
    output logic [31:0] redirect_pc_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        squash_ex_o,
    output logic        exc_misaligned_o,
    output logic        exc_illegal_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] taken_cnt_o
);

    br_state_t             state;
    logic [SQ_CNT_W-1:0]   sq_cnt;
    logic                  taken;
    logic                  illegal;
    logic                  eval;
    logic                  is_cond;
    logic                  misaligned;

    // Comparator signedness follows funct3[1] (BLTU/BGEU)
    assign br_unsigned_o = ex_funct3_i[1];

    br_cond u_cond (
        .funct3   (ex_funct3_i),
        .is_jump  (ex_is_jump_i),
        .br_less  (br_less_i),
        .br_equal (br_equal_i),
        .taken    (taken),
        .illegal  (illegal)
    );

    // A decision is made only from IDLE on an unstalled control-flow instruction
    assign eval       = (state == IDLE) && ex_valid_i && !ex_stall_i &&
                        (ex_is_branch_i || ex_is_jump_i);
    assign is_cond    = ex_is_branch_i && !ex_is_jump_i;
    assign misaligned = (ex_target_i[1:0] != 2'b00);

    // Redirect FSM, exception pulses and statistics counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            sq_cnt           <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_if_o       <= 1'b0;
            flush_id_o       <= 1'b0;
            squash_ex_o      <= 1'b0;
            exc_misaligned_o <= 1'b0;
            exc_illegal_o    <= 1'b0;
            branch_cnt_o     <= '0;
            taken_cnt_o      <= '0;
        end else begin
            exc_misaligned_o <= 1'b0;
            exc_illegal_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (eval) begin
                        if (is_cond) begin
                            branch_cnt_o  <= branch_cnt_o + 32'd1;
                            exc_illegal_o <= illegal;
                            if (taken) begin
                                taken_cnt_o <= taken_cnt_o + 32'd1;
                            end
                        end
                        if (taken) begin
                            if (misaligned) begin
                                exc_misaligned_o <= 1'b1;
                            end else begin
                                state            <= REDIRECT;
                                redirect_valid_o <= 1'b1;
                                redirect_pc_o    <= ex_target_i;
                                flush_if_o       <= 1'b1;
                                flush_id_o       <= 1'b1;
                                squash_ex_o      <= 1'b1;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    // The accept cycle counts as the first squash cycle
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        flush_if_o       <= 1'b0;
                        flush_id_o       <= 1'b0;
                        sq_cnt           <= SQ_CNT_W'(FLUSH_CYCLES - 1);
                        if (FLUSH_CYCLES == 1) begin
                            state       <= IDLE;
                            squash_ex_o <= 1'b0;
                        end else begin
                            state <= SQUASH;
                        end
                    end
                end
                SQUASH: begin
                    if (!ex_stall_i) begin
                        if (sq_cnt < SQ_CNT_W'(2)) begin
                            state       <= IDLE;
                            squash_ex_o <= 1'b0;
                            sq_cnt      <= '0;
                        end else begin
                            sq_cnt <= sq_cnt - SQ_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: directed test-plan sequences plus
// randomized traffic, checked by a scoreboard fed from a transaction-level model.
module tb_br_resolve;

    localparam int unsigned FLUSH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i;
    logic        ex_stall_i;
    logic        ex_is_branch_i;
    logic        ex_is_jump_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_target_i;
    logic        br_less_i;
    logic        br_equal_i;
    logic        br_unsigned_o;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        squash_ex_o;
    logic        exc_misaligned_o;
    logic        exc_illegal_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] taken_cnt_o;

    br_resolve #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ex_valid_i       (ex_valid_i),
        .ex_stall_i       (ex_stall_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_target_i      (ex_target_i),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .br_unsigned_o    (br_unsigned_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .flush_if_o       (flush_if_o),
        .flush_id_o       (flush_id_o),
        .squash_ex_o      (squash_ex_o),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_illegal_o    (exc_illegal_o),
        .branch_cnt_o     (branch_cnt_o),
        .taken_cnt_o      (taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expected per-cycle outputs, tagged with the cycle they belong to
    typedef struct {
        int          tag;
        logic        v;
        logic        fi;
        logic        fd;
        logic        sq;
        logic        mis;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pc_q[$];

    // Reference model: redirect outstanding, squash cycles left, counters
    bit          m_pend;
    int          m_sq;
    logic [31:0] m_pc;
    logic [31:0] m_bc;
    logic [31:0] m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Taken rule straight from the funct3 table
    function automatic bit ref_taken(input bit j, input logic [2:0] f3, input bit lt, input bit eq);
        if (j) return 1'b1;
        case (int'(f3))
            0:       return eq;
            1:       return !eq;
            4, 6:    return lt;
            5, 7:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one cycle using the inputs now applied
    task automatic model_step();
        exp_t e;
        bit   t;
        e.mis = 1'b0;
        e.ill = 1'b0;
        if (m_pend) begin
            if (redirect_ready_i) begin
                m_pend = 1'b0;
                m_sq   = int'(FLUSH) - 1;
            end
        end else if (m_sq > 0) begin
            if (!ex_stall_i) m_sq--;
        end else if (ex_valid_i && !ex_stall_i && (ex_is_branch_i || ex_is_jump_i)) begin
            t = ref_taken(ex_is_jump_i, ex_funct3_i, br_less_i, br_equal_i);
            if (!ex_is_jump_i) begin
                m_bc = m_bc + 32'd1;
                if (t) m_tc = m_tc + 32'd1;
                if (ex_funct3_i == 3'b010 || ex_funct3_i == 3'b011) e.ill = 1'b1;
            end
            if (t) begin
                if (ex_target_i[1:0] != 2'b00) begin
                    e.mis = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_pc   = ex_target_i;
                    pc_q.push_back(ex_target_i);
                end
            end
        end
        e.tag = cyc + 1;
        e.v   = m_pend;
        e.fi  = m_pend;
        e.fd  = m_pend;
        e.sq  = m_pend || (m_sq > 0);
        e.pc  = m_pc;
        e.bc  = m_bc;
        e.tc  = m_tc;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus, record expectations, advance to posedge+1
    task automatic drive(input logic v, input logic st, input logic br, input logic j,
                         input logic [2:0] f3, input logic [31:0] tgt,
                         input logic lt, input logic eq, input logic rdy);
        ex_valid_i       = v;
        ex_stall_i       = st;
        ex_is_branch_i   = br;
        ex_is_jump_i     = j;
        ex_funct3_i      = f3;
        ex_target_i      = tgt;
        br_less_i        = lt;
        br_equal_i       = eq;
        redirect_ready_i = rdy;
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_ctl", {26'b0, redirect_valid_o, flush_if_o, flush_id_o, squash_ex_o,
                        exc_misaligned_o, exc_illegal_o}, 32'h0);
        chk("rst_pc", redirect_pc_o, 32'h0);
        chk("rst_branch_cnt", branch_cnt_o, 32'h0);
        chk("rst_taken_cnt", taken_cnt_o, 32'h0);
        exp_q.delete();
        pc_q.delete();
        m_pend = 1'b0;
        m_sq   = 0;
        m_pc   = 32'h0;
        m_bc   = 32'h0;
        m_tc   = 32'h0;
        ex_valid_i       = 1'b0;
        ex_stall_i       = 1'b0;
        ex_is_branch_i   = 1'b0;
        ex_is_jump_i     = 1'b0;
        ex_funct3_i      = 3'b000;
        ex_target_i      = 32'h0;
        br_less_i        = 1'b0;
        br_equal_i       = 1'b0;
        redirect_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: per-cycle scoreboard compare and redirect transfer checking
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("br_unsigned", {31'b0, br_unsigned_o}, {31'b0, ex_funct3_i[1]});
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                mon_e = exp_q.pop_front();
                chk($sformatf("ctl@%0d", cyc),
                    {26'b0, redirect_valid_o, flush_if_o, flush_id_o, squash_ex_o,
                     exc_misaligned_o, exc_illegal_o},
                    {26'b0, mon_e.v, mon_e.fi, mon_e.fd, mon_e.sq, mon_e.mis, mon_e.ill});
                chk($sformatf("branch_cnt@%0d", cyc), branch_cnt_o, mon_e.bc);
                chk($sformatf("taken_cnt@%0d", cyc), taken_cnt_o, mon_e.tc);
                if (mon_e.v) chk($sformatf("held_pc@%0d", cyc), redirect_pc_o, mon_e.pc);
            end
            if (redirect_valid_o && redirect_ready_i) begin
                if (pc_q.size() == 0) begin
                    chk($sformatf("unexpected_redirect@%0d", cyc), 32'h1, 32'h0);
                end else begin
                    chk($sformatf("xfer_pc@%0d", cyc), redirect_pc_o, pc_q.pop_front());
                end
            end
        end
    end

    initial begin
        int          kind;
        logic [31:0] tgt;
        #1;
        do_reset();

        // Taken BEQ to 0x100, fetch ready
        drive(1, 0, 1, 0, 3'b000, 32'h0000_0100, 0, 1, 1);
        chk("beq_valid", {31'b0, redirect_valid_o}, 32'h1);
        chk("beq_pc", redirect_pc_o, 32'h0000_0100);
        chk("beq_flush", {30'b0, flush_if_o, flush_id_o}, 32'h3);
        chk("beq_counts", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, 32'h0001_0001);
        idle(1);
        chk("beq_squash2", {30'b0, redirect_valid_o, squash_ex_o}, 32'h1);
        idle(1);
        chk("beq_squash_end", {31'b0, squash_ex_o}, 32'h0);

        // BLTU not taken
        drive(1, 0, 1, 0, 3'b110, 32'h0000_0300, 0, 0, 1);
        chk("bltu_unsigned", {31'b0, br_unsigned_o}, 32'h1);
        chk("bltu_no_redirect", {31'b0, redirect_valid_o}, 32'h0);
        chk("bltu_counts", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, 32'h0002_0001);

        // JAL to 0x200 with fetch busy for 3 cycles; EX branches ignored
        drive(1, 0, 0, 1, 3'b000, 32'h0000_0200, 0, 0, 0);
        chk("jal_valid", {31'b0, redirect_valid_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 3'b000, 32'h0000_0300, 0, 1, 0);
            chk("jal_hold_valid", {31'b0, redirect_valid_o}, 32'h1);
            chk("jal_hold_pc", redirect_pc_o, 32'h0000_0200);
            chk("jal_counts", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, 32'h0002_0001);
        end
        idle(1);
        chk("jal_accepted", {30'b0, redirect_valid_o, squash_ex_o}, 32'h1);
        idle(1);

        // Taken BNE to a misaligned target
        drive(1, 0, 1, 0, 3'b001, 32'h0000_0102, 0, 0, 1);
        chk("bne_misaligned", {30'b0, exc_misaligned_o, redirect_valid_o}, 32'h2);
        chk("bne_taken_cnt", taken_cnt_o, 32'd2);
        idle(1);
        chk("bne_pulse_once", {31'b0, exc_misaligned_o}, 32'h0);

        // Reserved funct3 010
        drive(1, 0, 1, 0, 3'b010, 32'h0000_0400, 1, 1, 1);
        chk("f3_010_illegal", {30'b0, exc_illegal_o, redirect_valid_o}, 32'h2);
        chk("f3_010_branch_cnt", branch_cnt_o, 32'd4);

        // Taken BGE, accept, then reset while squashing
        drive(1, 0, 1, 0, 3'b101, 32'h0000_0500, 0, 0, 1);
        idle(1);
        chk("bge_in_squash", {30'b0, redirect_valid_o, squash_ex_o}, 32'h1);
        chk("bge_counts", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, 32'h0005_0003);
        do_reset();

        // First case again after reset
        drive(1, 0, 1, 0, 3'b000, 32'h0000_0100, 0, 1, 1);
        chk("rbeq_valid_pc", {redirect_valid_o, redirect_pc_o[30:0]}, 32'h8000_0100);
        chk("rbeq_counts", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, 32'h0001_0001);
        idle(1);
        idle(1);

        // Reserved funct3 011, stalled for one cycle first
        drive(1, 1, 1, 0, 3'b011, 32'h0000_0600, 0, 1, 1);
        chk("stall_no_eval", branch_cnt_o, 32'd1);
        drive(1, 0, 1, 0, 3'b011, 32'h0000_0600, 0, 1, 1);
        chk("f3_011_illegal", {31'b0, exc_illegal_o}, 32'h1);
        chk("f3_011_branch_cnt", branch_cnt_o, 32'd2);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 2));
            tgt  = $urandom;
            if ($urandom_range(0, 4) != 0) tgt[1:0] = 2'b00;
            drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
                  1'(kind == 1), 1'(kind == 2), 3'($urandom), tgt,
                  1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 200) do_reset();
        end

        for (int k = 0; k < 10; k++) idle(1);
        @(negedge clk_i);
        chk("pc_q_drained", pc_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
# br_resolve

Branch-resolution and redirect unit for the EX stage of the stalling RV32I pipeline. It is the consumer of the branch comparator: it drives the comparator's signedness select, reads back `br_less`/`br_equal`, and decides whether a conditional branch or jump is taken. On a taken decision it issues a registered PC redirect to the fetch stage with a valid/ready handshake, flushes IF/ID, and squashes wrong-path instructions reaching EX.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of non-stalled cycles, including the redirect-accept cycle, during which the EX instruction is squashed after a redirect. Legal range is 1..7.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `ex_valid_i` in 1: EX holds a valid instruction.
- `ex_stall_i` in 1: the hazard unit is freezing EX.
- `ex_is_branch_i` in 1: B-type instruction in EX.
- `ex_is_jump_i` in 1: JAL/JALR in EX.
- `ex_funct3_i` in 3: funct3 of the EX instruction.
- `ex_target_i` in 32: computed branch/jump target.
- `br_less_i` in 1: less-than result from the comparator.
- `br_equal_i` in 1: equal result from the comparator.
- `br_unsigned_o` out 1: comparator signedness select, driven combinationally as `ex_funct3_i[1]`.
- `redirect_valid_o` out 1: redirect request to fetch.
- `redirect_ready_i` in 1: fetch accepts the redirect.
- `redirect_pc_o` out 32: redirect target, registered.
- `flush_if_o` out 1: squash IF.
- `flush_id_o` out 1: squash ID.
- `squash_ex_o` out 1: the instruction currently in EX is wrong-path.
- `exc_misaligned_o` out 1: one-cycle pulse for a taken target with `[1:0] != 0`.
- `exc_illegal_o` out 1: one-cycle pulse for a branch with funct3 010 or 011.
- `branch_cnt_o` out 32: count of evaluated conditional branches.
- `taken_cnt_o` out 32: count of taken conditional branches.

## Operation
- An evaluation occurs when the state is IDLE, `ex_valid_i` is 1, `ex_stall_i` is 0, and either `ex_is_branch_i` or `ex_is_jump_i` is 1. No evaluation occurs in any other state.
- Taken decode by funct3:
  - 000 → `equal`; 001 → `!equal`.
  - 100 → `less`; 101 → `!less`.
  - 110 → `less`; 111 → `!less`.
  - 010 and 011 → not taken; pulse `exc_illegal_o`.
  - A jump is always taken; funct3 is ignored.
- If taken and `ex_target_i[1:0] != 0`: pulse `exc_misaligned_o`, issue no redirect, stay in IDLE.
- FSM:
  - IDLE → REDIRECT on a taken, aligned evaluation. Latch `redirect_pc_o = ex_target_i`.
  - REDIRECT: hold `redirect_valid_o`, `flush_if_o`, `flush_id_o`, and `squash_ex_o` at 1, with `redirect_pc_o` stable, until `redirect_ready_i` is 1.
    - Acceptance cycle: load the squash counter with `FLUSH_CYCLES-1`.
    - Then go to SQUASH, or to IDLE if `FLUSH_CYCLES == 1`.
  - SQUASH: `squash_ex_o` is 1 and all other redirect outputs are 0. The counter decrements on each cycle with `ex_stall_i` = 0; go to IDLE when it would reach 0.
  - Stalls in REDIRECT or SQUASH do not cancel the request. EX inputs are ignored in both states.
- Counters:
  - `branch_cnt_o` increments on every conditional-branch evaluation, illegal funct3 included.
  - `taken_cnt_o` increments on taken conditional branches, misaligned ones included.
  - Jumps increment neither counter.
  - Both wrap modulo 2^32.

## Timing
- Reset values: every output is 0, the state is IDLE, and the counters are 0. `br_unsigned_o` is combinational and follows `ex_funct3_i[1]`.
- Evaluation in cycle N gives:
  - `redirect_valid_o`, flushes, and `squash_ex_o` high from cycle N+1;
  - exception pulses in cycle N+1 only;
  - counters updated at the N+1 edge.
- Handshake:
  - Transfer occurs on the rising edge where valid and ready are both 1.
  - `redirect_valid_o` falls in the following cycle.
  - `redirect_valid_o` never falls without a transfer, except on reset.
- `redirect_ready_i` high in cycle N+1 plus `FLUSH_CYCLES` = 2 with no stalls: `squash_ex_o` is high in cycles N+1 and N+2 and low in N+3.
- Reset mid-operation: `rst_ni` low clears state, counters, and outputs immediately, asynchronously. Any pending redirect is dropped.
- `ex_stall_i` high in IDLE: no evaluation and no counter change. The decision is made in the first unstalled cycle.

## Structure
- Package `br_pkg` holds:
  - funct3 localparams (`F3_BEQ` through `F3_BGEU`);
  - the FSM state enum `br_state_t` {IDLE, REDIRECT, SQUASH};
  - the squash counter width (3 bits).
- Sub-module `br_cond`: combinational taken/illegal decode from funct3, `is_jump`, `br_less`, and `br_equal`. The FSM, counters, and registers stay in `br_resolve`.

## Test plan
- BEQ, `br_equal_i`=1, target 0x0000_0100, ready=1 → N+1: valid=1, pc=0x100, flushes=1; `squash_ex_o` high for 2 cycles; branch/taken counts are 1/1.
- BLTU (funct3 110), `br_less_i`=0 → `br_unsigned_o`=1, no redirect, counts are 1/0.
- JAL to 0x200 with ready low for 3 cycles → valid and `pc=0x200` held 4 cycles; EX branches presented meanwhile are ignored; counts unchanged.
- Taken BNE to 0x0000_0102 → `exc_misaligned_o` pulses once, no redirect, `taken_cnt_o`=1.
- funct3 010 branch → `exc_illegal_o` pulses, not taken, `branch_cnt_o`=1; funct3 011 behaves identically.
- `rst_ni` low during SQUASH with counters at 5/3 → all outputs 0 at once, counts 0/0; the next BEQ taken behaves as in the first case.
